// File: rtl/z_angle_table_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// z_angle_table_loader : streams 2**ADDR_WIDTH words into a table, then
// optionally reads them back and compares a checksum.     Rev 1.0
// ---------------------------------------------------------------------------
module z_angle_table_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 7,
  parameter int VERIFY_EN  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             s_valid,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             s_ready,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_sum
);

  localparam int                    SUM_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, done_q, err_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wcnt_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [SUM_WIDTH-1:0]  wr_sum_q, rd_sum_q, rd_sum_d;
  logic                  rd_act_q, rd_vld_q, rd_last_q;
  logic                  accept, last_acc, load_go;

  assign accept   = s_valid && (state_q == S_WRITE);
  assign last_acc = accept && (wcnt_q == LAST_ADDR);
  assign load_go  = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign rd_sum_d = rd_sum_q + SUM_WIDTH'(rd_data);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_WRITE;
      S_WRITE:  if (last_acc) state_d = (VERIFY_EN != 0) ? S_VERIFY : S_DONE;
      // rd_last_q marks the cycle the final read word arrives; fold it in before comparing
      S_VERIFY: if (rd_last_q) state_d = (rd_sum_d == wr_sum_q) ? S_DONE : S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_WRITE) || (state_d == S_VERIFY);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wcnt_q    <= '0;
      wr_sum_q  <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= wcnt_q;
        wr_data_q <= s_data;
      end
      if (load_go) begin
        wcnt_q   <= '0;
        wr_sum_q <= '0;
      end else if (accept) begin
        wcnt_q   <= wcnt_q + 1'b1;
        wr_sum_q <= wr_sum_q + SUM_WIDTH'(s_data);
      end
    end
  end

  // Read side: rd_vld_q/rd_last_q trail the address by one cycle to match table latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_act_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_addr_q <= '0;
      rd_sum_q  <= '0;
    end else begin
      rd_vld_q  <= rd_act_q;
      rd_last_q <= rd_act_q && (rd_addr_q == LAST_ADDR);
      if (load_go) begin
        rd_act_q  <= 1'b0;
        rd_addr_q <= '0;
      end else if (last_acc && (VERIFY_EN != 0)) begin
        rd_act_q <= 1'b1;
      end else if (rd_act_q) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        if (rd_addr_q == LAST_ADDR) rd_act_q <= 1'b0;
      end
      if (load_go)       rd_sum_q <= '0;
      else if (rd_vld_q) rd_sum_q <= rd_sum_d;
    end
  end

  assign s_ready = (state_q == S_WRITE);
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wr_sum  = wr_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_z_angle_table_loader.sv
`default_nettype none
// Bench for z_angle_table_loader: full loads against a behavioural table with a
// write-port scoreboard, plus reset, restart and no-verify corner cases.
module tb_z_angle_table_loader;

  localparam int AW  = 12;
  localparam int DW  = 7;
  localparam int SW  = AW + DW;
  localparam int NW  = 1 << AW;
  localparam int AW2 = 4;
  localparam int SW2 = AW2 + DW;
  localparam int NW2 = 1 << AW2;

  logic          clk = 1'b0;
  logic          rst, start, s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_sum;

  logic           start2, s_valid2;
  logic [DW-1:0]  s_data2;
  logic           s_ready2, wr_en2, busy2, done2, err2;
  logic [AW2-1:0] wr_addr2, rd_addr2;
  logic [DW-1:0]  wr_data2;
  logic [DW-1:0]  rd_data2 = '0;
  logic [SW2-1:0] wr_sum2;

  always #5 clk = ~clk;

  z_angle_table_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VERIFY_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .wr_sum(wr_sum)
  );

  z_angle_table_loader #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .VERIFY_EN(0)) dut_nv (
    .clk(clk), .rst(rst), .start(start2), .s_valid(s_valid2), .s_data(s_data2),
    .s_ready(s_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .done(done2), .err(err2),
    .wr_sum(wr_sum2)
  );

  // Table model: registered read, optional single-bit corruption at 12'h800
  logic [DW-1:0] mem [NW];
  logic          corrupt_en = 1'b0;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr] ^ ((corrupt_en && rd_addr == 12'h800) ? 7'h01 : 7'h00);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  int            n_wr = 0;
  logic [AW-1:0] last_wr_addr = '0;

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && wr_en) begin
        n_wr++;
        last_wr_addr = wr_addr;
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_extra_write: actual wr_addr=%0h required no write", wr_addr);
        end else begin
          e = sb.pop_front();
          chk("sb_wr_addr", wr_addr, e.addr);
          chk("sb_wr_data", wr_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // mode 0: all 7'h7F, mode 1: addr[6:0]; vpat 1 toggles s_valid every cycle
  task automatic run_load(input int mode, input int vpat, input int start_mid, input int abort_at);
    int   n;
    int   cyc;
    logic ph;
    logic v;
    n = 0; cyc = 0; ph = 1'b0;
    sb.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
    chk("start_sum_clr", wr_sum, 0);
    while (n < NW && cyc < 4 * NW) begin
      v  = (vpat == 0) ? 1'b1 : ph;
      ph = ~ph;
      start   = (start_mid != 0 && n == start_mid);
      s_valid = v;
      s_data  = (mode == 0) ? 7'h7F : DW'(n);
      if (v && s_ready) begin
        sb.push_back({AW'(n), s_data});
        n++;
      end
      @(negedge clk);
      cyc++;
      if (abort_at != 0 && n == abort_at) break;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (abort_at == 0) begin
      chk("load_in_budget", cyc < 4 * NW, 1);
      chk("ready_drop_after_last", s_ready, 0);
    end
  endtask

  task automatic wait_end();
    int c;
    c = 0;
    while (!(done || err) && c < 3 * NW) begin
      @(negedge clk);
      c++;
    end
    chk("end_timeout", done || err, 1);
  endtask

  typedef struct {
    int            mode;
    int            vpat;
    logic          corrupt;
    int            start_mid;
    logic          exp_done;
    logic          exp_err;
    logic [SW-1:0] exp_sum;
  } vec_t;

  vec_t vecs[3];

  initial begin : main
    int base;
    int sum2;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    start2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
    vecs[0] = '{0, 0, 1'b0, 0,  1'b1, 1'b0, 19'h7F000};
    vecs[1] = '{1, 1, 1'b0, 50, 1'b1, 1'b0, 19'h3F800};
    vecs[2] = '{0, 0, 1'b1, 0,  1'b0, 1'b1, 19'h7F000};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_sum", wr_sum, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_ready", s_ready, 0);

    for (int i = 0; i < 3; i++) begin
      corrupt_en = vecs[i].corrupt;
      base = n_wr;
      run_load(vecs[i].mode, vecs[i].vpat, vecs[i].start_mid, 0);
      wait_end();
      chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_wr_sum", i), wr_sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_wr_pulses", i), n_wr - base, NW);
      chk($sformatf("v%0d_last_wr_addr", i), last_wr_addr, 12'hFFF);
      chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
      chk($sformatf("v%0d_rd_addr_idle", i), rd_addr, 0);
    end
    corrupt_en = 1'b0;

    // Reset after 100 accepted words: async clear, no resume, clean restart
    base = n_wr;
    run_load(1, 0, 0, 100);
    chk("abort_wr_pulses", n_wr - base, 100);
    chk("abort_last_addr", last_wr_addr, 99);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_wr_sum", wr_sum, 0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_resume_ready", s_ready, 0);
    chk("no_resume_busy", busy, 0);
    chk("no_resume_wr_en", wr_en, 0);
    base = n_wr;
    run_load(0, 0, 0, 0);
    wait_end();
    chk("restart_done", done, 1);
    chk("restart_wr_pulses", n_wr - base, NW);
    chk("restart_wr_sum", wr_sum, 19'h7F000);

    // start pulsed during VERIFY is ignored
    run_load(1, 0, 0, 0);
    repeat (200) @(negedge clk);
    chk("sv_busy", busy, 1);
    chk("sv_rd_addr_step", rd_addr, 200);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("sv_ignored_ready", s_ready, 0);
    chk("sv_ignored_busy", busy, 1);
    chk("sv_rd_addr_cont", rd_addr, 201);
    wait_end();
    chk("sv_done", done, 1);
    chk("sv_err", err, 0);
    chk("sv_wr_sum", wr_sum, 19'h3F800);
    chk("sv_rd_addr_idle", rd_addr, 0);

    // VERIFY_EN=0 instance: DONE right after the last write, rd_addr untouched
    sum2 = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int k = 0; k < NW2; k++) begin
      s_valid2 = 1'b1;
      s_data2  = DW'(k + 1);
      sum2    += k + 1;
      chk("nv_ready", s_ready2, 1);
      chk("nv_rd_addr", rd_addr2, 0);
      @(negedge clk);
      chk("nv_wr_en", wr_en2, 1);
      chk("nv_wr_addr", wr_addr2, k);
      chk("nv_wr_data", wr_data2, k + 1);
    end
    s_valid2 = 1'b0;
    chk("nv_done", done2, 1);
    chk("nv_busy", busy2, 0);
    chk("nv_err", err2, 0);
    chk("nv_wr_sum", wr_sum2, sum2);
    chk("nv_rd_addr_end", rd_addr2, 0);
    @(negedge clk);
    chk("nv_wr_en_off", wr_en2, 0);
    chk("nv_done_hold", done2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
